ro_age_evaluator: RTL

- Measurement sequencer and evaluator placed directly downstream of the RO odometer top.
- Drives the odometer's go/en_out handshake and captures N reference/stressed frequency pairs.
- Averages the stressed-vs-reference difference and compares the average against a threshold to flag an aged/recycled device.
- Results are exposed to the security-engine register interface.

---
 rtl/ro_odometer_pkg.sv | 36 +++
 rtl/ro_age_evaluator_if.sv | 31 +++
 rtl/ro_age_evaluator_diff_accum.sv | 74 +++++++
 rtl/ro_age_evaluator.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/ro_odometer_pkg.sv
// Shared types and constants for the RO odometer and its age evaluator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ro_odometer_pkg;

  // Width of the reference/stressed ring-oscillator counts.
  localparam int FREQ_W = 32;

  // Default decision threshold on the averaged (r_freq - s_freq) difference.
  localparam logic [FREQ_W-1:0] AGE_THRESH_DEF = 32'd50;

  // Default number of cycles to wait for the odometer before giving up.
  localparam int TIMEOUT_DEF = 1024;

  // Evaluator FSM states, one-hot so each state decodes from a single flop.
  typedef enum logic [5:0] {
    S_IDLE   = 6'b000001,
    S_REQ    = 6'b000010,
    S_WAIT   = 6'b000100,
    S_CAPT   = 6'b001000,
    S_RESUME = 6'b010000,
    S_DONE   = 6'b100000
  } state_t;

  // r - s evaluated with one extra sign bit; a stressed count above the
  // reference means no measurable ageing, so it contributes zero.
  function automatic logic [FREQ_W-1:0] clamp_diff(
    input logic [FREQ_W-1:0] r,
    input logic [FREQ_W-1:0] s
  );
    logic signed [FREQ_W:0] d;
    d = $signed({1'b0, r}) - $signed({1'b0, s});
    return d[FREQ_W] ? '0 : d[FREQ_W-1:0];
  endfunction

endpackage

// File: rtl/ro_age_evaluator_if.sv
// Handshake and data bundle between the RO odometer and the age evaluator.
// Latency: n/a (wiring only).
// Backpressure: odometer holds odo_valid and its counts until odo_go.
interface ro_age_evaluator_if;
  import ro_odometer_pkg::*;

  logic              odo_go;
  logic              odo_en_out;
  logic              odo_valid;
  logic [FREQ_W-1:0] r_freq;
  logic [FREQ_W-1:0] s_freq;

  // Evaluator side: issues the requests, receives the measurements.
  modport master (
    output odo_go,
    output odo_en_out,
    input  odo_valid,
    input  r_freq,
    input  s_freq
  );

  // Odometer side.
  modport slave (
    input  odo_go,
    input  odo_en_out,
    output odo_valid,
    output r_freq,
    output s_freq
  );

endinterface

// File: rtl/ro_age_evaluator_diff_accum.sv
// Clamped r-s subtraction, accumulation, shift-average and threshold compare.
// Latency: one cycle per capture; result registers load on the fin strobe.
// Backpressure: none; driven purely by the evaluator FSM strobes.
// Optional min/max tracking is built when RO_AGE_MINMAX_EN is defined.
module ro_diff_accum
  import ro_odometer_pkg::*;
#(
  parameter int                NUM_SAMPLES = 8,
  parameter logic [FREQ_W-1:0] AGE_THRESH  = AGE_THRESH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              capt,
  input  logic              fin,
  input  logic [FREQ_W-1:0] r_freq,
  input  logic [FREQ_W-1:0] s_freq,
  output logic [FREQ_W-1:0] diff_avg,
  output logic              aged
`ifdef RO_AGE_MINMAX_EN
  ,
  output logic [FREQ_W-1:0] diff_min,
  output logic [FREQ_W-1:0] diff_max
`endif
);

  localparam int LOG2_N = $clog2(NUM_SAMPLES);
  // Sum of NUM_SAMPLES 32-bit values needs exactly LOG2_N extra bits.
  localparam int ACC_W  = FREQ_W + LOG2_N;

  logic [ACC_W-1:0]  acc;
  logic [FREQ_W-1:0] diff;
  logic [FREQ_W-1:0] avg;

  assign diff = clamp_diff(r_freq, s_freq);
  // NUM_SAMPLES is a power of two, so the mean is a plain truncating shift.
  assign avg  = FREQ_W'(acc >> LOG2_N);

  // Accumulate clamped differences; publish average and verdict on fin.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc      <= '0;
      diff_avg <= '0;
      aged     <= 1'b0;
    end else begin
      if (clr) begin
        acc <= '0;
      end else if (capt) begin
        acc <= acc + ACC_W'(diff);
      end
      if (fin) begin
        diff_avg <= avg;
        aged     <= (avg >= AGE_THRESH);
      end
    end
  end

`ifdef RO_AGE_MINMAX_EN
  // Track the spread of per-sample differences within the current run.
  always_ff @(posedge clk) begin
    if (!rst) begin
      diff_min <= '0;
      diff_max <= '0;
    end else if (clr) begin
      diff_min <= '1;
      diff_max <= '0;
    end else if (capt) begin
      if (diff < diff_min) diff_min <= diff;
      if (diff > diff_max) diff_max <= diff;
    end
  end
`endif

endmodule

// File: rtl/ro_age_evaluator.sv
// Sequences NUM_SAMPLES odometer measurements and flags an aged device.
// Latency: sum of odometer times + 3 cycles/sample + 1; results on done.
// Backpressure: start ignored while busy or on the done cycle; no queuing.
// Optional diff_min/diff_max outputs are built when RO_AGE_MINMAX_EN is defined.
module ro_age_evaluator
  import ro_odometer_pkg::*;
#(
  parameter int                NUM_SAMPLES = 8,
  parameter logic [FREQ_W-1:0] AGE_THRESH  = AGE_THRESH_DEF,
  parameter int                TIMEOUT     = TIMEOUT_DEF,
  parameter int                CNT_W       = $clog2(NUM_SAMPLES) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  ro_age_evaluator_if.master  odo,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  output logic [FREQ_W-1:0]   diff_avg,
  output logic                aged,
  output logic [CNT_W-1:0]    sample_cnt
`ifdef RO_AGE_MINMAX_EN
  ,
  output logic [FREQ_W-1:0]   diff_min,
  output logic [FREQ_W-1:0]   diff_max
`endif
);

  localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_SAMPLES);

  state_t           state;
  logic             valid_q;
  logic             valid_rise;
  logic [TMO_W-1:0] tmo_cnt;
  logic             go_q;
  logic             en_q;
  logic             start_ok;
  logic             acc_clr;
  logic             acc_capt;
  logic             acc_fin;

  assign odo.odo_go     = go_q;
  assign odo.odo_en_out = en_q;

  // Only a fresh 0->1 transition counts: the odometer keeps valid high until
  // it sees go, so the old level from the previous sample must not be reused.
  assign valid_rise = odo.odo_valid & ~valid_q;

  // done is also high on the first idle cycle after a timeout; a start that
  // coincides with it is dropped so every run begins from a quiet interface.
  assign start_ok = (state == S_IDLE) & start & ~done;

  assign acc_clr  = start_ok;
  assign acc_capt = (state == S_CAPT);
  assign acc_fin  = (state == S_RESUME) & (sample_cnt == CNT_LAST);

  // Delayed copy of the odometer valid level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= odo.odo_valid;
    end
  end

  // Measurement sequencer; all handshake and status outputs are registered
  // on the transition into the state that owns them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      sample_cnt  <= '0;
      tmo_cnt     <= '0;
      go_q        <= 1'b0;
      en_q        <= 1'b0;
    end else begin
      done <= 1'b0;
      go_q <= 1'b0;
      en_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start_ok) begin
            state       <= S_REQ;
            busy        <= 1'b1;
            sample_cnt  <= '0;
            timeout_err <= 1'b0;
            en_q        <= 1'b1;
          end
        end
        S_REQ: begin
          state   <= S_WAIT;
          tmo_cnt <= '0;
        end
        S_WAIT: begin
          if (valid_rise) begin
            state <= S_CAPT;
          end else if (tmo_cnt == TMO_LAST) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b1;
            timeout_err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        S_CAPT: begin
          sample_cnt <= sample_cnt + 1'b1;
          state      <= S_RESUME;
          go_q       <= 1'b1;
        end
        S_RESUME: begin
          if (sample_cnt == CNT_LAST) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state <= S_REQ;
            en_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  ro_diff_accum #(
    .NUM_SAMPLES (NUM_SAMPLES),
    .AGE_THRESH  (AGE_THRESH)
  ) u_accum (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .capt     (acc_capt),
    .fin      (acc_fin),
    .r_freq   (odo.r_freq),
    .s_freq   (odo.s_freq),
    .diff_avg (diff_avg),
    .aged     (aged)
`ifdef RO_AGE_MINMAX_EN
    ,
    .diff_min (diff_min),
    .diff_max (diff_max)
`endif
  );

endmodule
